// File: rtl/axi_r_ch.sv
// AXI read-data channel router. Three slaves feed two masters, and the upper RID nibble selects the master.
// Each master has round-robin arbitration with a per-burst lock. Define AXI_R_CH_SKID_EN for a 2-entry skid buffer per master output.
module axi_r_ch #(
   parameter int ID_BITS   = 4,
   parameter int IDS_BITS  = 8,
   parameter int DATA_BITS = 32,
   parameter int RESP_BITS = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [IDS_BITS-1:0]  id_s0_i,
   input  logic [DATA_BITS-1:0] data_s0_i,
   input  logic [RESP_BITS-1:0] resp_s0_i,
   input  logic                 last_s0_i,
   input  logic                 valid_s0_i,
   output logic                 ready_s0_o,
   input  logic [IDS_BITS-1:0]  id_s1_i,
   input  logic [DATA_BITS-1:0] data_s1_i,
   input  logic [RESP_BITS-1:0] resp_s1_i,
   input  logic                 last_s1_i,
   input  logic                 valid_s1_i,
   output logic                 ready_s1_o,
   input  logic [IDS_BITS-1:0]  id_s2_i,
   input  logic [DATA_BITS-1:0] data_s2_i,
   input  logic [RESP_BITS-1:0] resp_s2_i,
   input  logic                 last_s2_i,
   input  logic                 valid_s2_i,
   output logic                 ready_s2_o,
   output logic [ID_BITS-1:0]   id_m0_o,
   output logic [DATA_BITS-1:0] data_m0_o,
   output logic [RESP_BITS-1:0] resp_m0_o,
   output logic                 last_m0_o,
   output logic                 valid_m0_o,
   input  logic                 ready_m0_i,
   output logic [ID_BITS-1:0]   id_m1_o,
   output logic [DATA_BITS-1:0] data_m1_o,
   output logic [RESP_BITS-1:0] resp_m1_o,
   output logic                 last_m1_o,
   output logic                 valid_m1_o,
   input  logic                 ready_m1_i
);
   localparam int TAG_BITS  = IDS_BITS - ID_BITS;
   localparam int BEAT_BITS = ID_BITS + DATA_BITS + RESP_BITS + 1;

   typedef enum logic {ST_IDLE, ST_LOCK} state_t;
   typedef logic [BEAT_BITS-1:0] beat_t;

   function automatic logic [1:0] inc3(input logic [1:0] x);
      return (x == 2'd2) ? 2'd0 : x + 2'd1;
   endfunction

   // Slot 3 is a permanently idle dummy so any 2-bit slave index stays in range.
   beat_t               w_s_beat [4];
   logic [3:0]          w_s_valid;
   logic [TAG_BITS-1:0] w_s_tag  [3];
   logic [2:0]          w_orphan;
   logic [1:0][2:0]     w_grant;
   logic [1:0]          w_m_ready;
   logic [1:0]          w_m_valid;
   beat_t               w_m_beat [2];

   assign w_s_beat[0] = {id_s0_i[ID_BITS-1:0], data_s0_i, resp_s0_i, last_s0_i};
   assign w_s_beat[1] = {id_s1_i[ID_BITS-1:0], data_s1_i, resp_s1_i, last_s1_i};
   assign w_s_beat[2] = {id_s2_i[ID_BITS-1:0], data_s2_i, resp_s2_i, last_s2_i};
   assign w_s_beat[3] = '0;
   assign w_s_valid   = {1'b0, valid_s2_i, valid_s1_i, valid_s0_i};
   assign w_s_tag[0]  = id_s0_i[IDS_BITS-1:ID_BITS];
   assign w_s_tag[1]  = id_s1_i[IDS_BITS-1:ID_BITS];
   assign w_s_tag[2]  = id_s2_i[IDS_BITS-1:ID_BITS];
   assign w_m_ready   = {ready_m1_i, ready_m0_i};

   always_comb begin
      for (int s = 0; s < 3; s++)
         w_orphan[s] = w_s_valid[s] && (w_s_tag[s] != TAG_BITS'(1)) && (w_s_tag[s] != TAG_BITS'(2));
   end

   for (genvar m = 0; m < 2; m++) begin : g_path
      state_t     r_state, w_state_nxt;
      logic [1:0] r_src, r_rr, w_src_nxt, w_rr_nxt, w_sel;
      logic [1:0] w_order [3];
      logic [3:0] w_cand;
      logic       w_sel_act, w_sel_valid, w_last, w_hs, w_int_ready;
      beat_t      w_beat;

      always_comb begin
         w_cand[3] = 1'b0;
         for (int s = 0; s < 3; s++)
            w_cand[s] = w_s_valid[s] && (w_s_tag[s] == TAG_BITS'(m + 1));
      end

      assign w_order[0] = r_rr;
      assign w_order[1] = inc3(r_rr);
      assign w_order[2] = inc3(inc3(r_rr));

      // NOTE: every combinational output gets a default first so no path can infer a latch.
      always_comb begin
         w_sel     = r_src;
         w_sel_act = (r_state == ST_LOCK);
         if (r_state == ST_IDLE) begin
            // Scan lowest priority first so the highest-priority candidate is written last.
            for (int k = 2; k >= 0; k--) begin
               if (w_cand[w_order[k]]) begin
                  w_sel     = w_order[k];
                  w_sel_act = 1'b1;
               end
            end
         end
      end

      assign w_sel_valid = w_sel_act & w_s_valid[w_sel];
      assign w_beat      = w_sel_valid ? w_s_beat[w_sel] : '0;
      assign w_last      = w_beat[0];
      assign w_hs        = w_sel_valid & w_int_ready;
      assign w_grant[m]  = {w_sel_act && (w_sel == 2'd2), w_sel_act && (w_sel == 2'd1),
                            w_sel_act && (w_sel == 2'd0)} & {3{w_int_ready}};

      always_comb begin
         w_state_nxt = r_state;
         w_src_nxt   = r_src;
         w_rr_nxt    = r_rr;
         case (r_state)
            ST_IDLE: begin
               if (w_sel_valid) begin
                  if (w_hs && w_last) begin
                     w_rr_nxt = inc3(w_sel);
                  end else begin
                     w_state_nxt = ST_LOCK;
                     w_src_nxt   = w_sel;
                  end
               end
            end
            ST_LOCK: begin
               if (w_hs && w_last) begin
                  w_state_nxt = ST_IDLE;
                  w_rr_nxt    = inc3(r_src);
               end
            end
            default: w_state_nxt = ST_IDLE;
         endcase
      end

      // NOTE: sequential state uses non-blocking assignments only.
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            r_state <= ST_IDLE;
            r_src   <= '0;
            r_rr    <= '0;
         end else begin
            r_state <= w_state_nxt;
            r_src   <= w_src_nxt;
            r_rr    <= w_rr_nxt;
         end
      end

`ifdef AXI_R_CH_SKID_EN
      logic  r_main_v, r_skid_v;
      beat_t r_main, r_skid;

      assign w_int_ready  = ~r_skid_v;
      assign w_m_valid[m] = r_main_v;
      assign w_m_beat[m]  = r_main;

      // NOTE: payload registers are reset too, so the master sees zeros while rst is low.
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            r_main_v <= 1'b0;
            r_skid_v <= 1'b0;
            r_main   <= '0;
            r_skid   <= '0;
         end else if (!r_main_v || w_m_ready[m]) begin
            if (r_skid_v) begin
               r_main_v <= 1'b1;
               r_main   <= r_skid;
               r_skid_v <= 1'b0;
            end else begin
               r_main_v <= w_hs;
               r_main   <= w_beat;
            end
         end else if (w_hs) begin
            r_skid_v <= 1'b1;
            r_skid   <= w_beat;
         end
      end
`else
      assign w_int_ready  = w_m_ready[m];
      assign w_m_valid[m] = w_sel_valid & rst;
      assign w_m_beat[m]  = rst ? w_beat : '0;
`endif
   end

   assign {id_m0_o, data_m0_o, resp_m0_o, last_m0_o} = w_m_beat[0];
   assign {id_m1_o, data_m1_o, resp_m1_o, last_m1_o} = w_m_beat[1];
   assign valid_m0_o = w_m_valid[0];
   assign valid_m1_o = w_m_valid[1];

   // Gating with rst keeps every ready low during reset even if the combinational path is active.
   assign ready_s0_o = rst & (w_grant[0][0] | w_grant[1][0] | w_orphan[0]);
   assign ready_s1_o = rst & (w_grant[0][1] | w_grant[1][1] | w_orphan[1]);
   assign ready_s2_o = rst & (w_grant[0][2] | w_grant[1][2] | w_orphan[2]);
endmodule

// File: tb/tb_axi_r_ch.sv
// Self-checking bench for axi_r_ch (default zero-latency build): directed scenarios plus
// randomized traffic compared against a behavioural routing model.
module tb_axi_r_ch;
   logic             clk = 1'b0;
   logic             rst;
   logic [2:0][7:0]  sid;
   logic [2:0][31:0] sdata;
   logic [2:0][1:0]  sresp;
   logic [2:0]       slast, svalid, srdy;
   logic [1:0][3:0]  mid;
   logic [1:0][31:0] mdata;
   logic [1:0][1:0]  mresp;
   logic [1:0]       mlast, mvalid, mrdy;
   int               n_chk = 0;
   int               n_err = 0;

   axi_r_ch dut (
      .clk(clk), .rst(rst),
      .id_s0_i(sid[0]), .data_s0_i(sdata[0]), .resp_s0_i(sresp[0]), .last_s0_i(slast[0]),
      .valid_s0_i(svalid[0]), .ready_s0_o(srdy[0]),
      .id_s1_i(sid[1]), .data_s1_i(sdata[1]), .resp_s1_i(sresp[1]), .last_s1_i(slast[1]),
      .valid_s1_i(svalid[1]), .ready_s1_o(srdy[1]),
      .id_s2_i(sid[2]), .data_s2_i(sdata[2]), .resp_s2_i(sresp[2]), .last_s2_i(slast[2]),
      .valid_s2_i(svalid[2]), .ready_s2_o(srdy[2]),
      .id_m0_o(mid[0]), .data_m0_o(mdata[0]), .resp_m0_o(mresp[0]), .last_m0_o(mlast[0]),
      .valid_m0_o(mvalid[0]), .ready_m0_i(mrdy[0]),
      .id_m1_o(mid[1]), .data_m1_o(mdata[1]), .resp_m1_o(mresp[1]), .last_m1_o(mlast[1]),
      .valid_m1_o(mvalid[1]), .ready_m1_i(mrdy[1])
   );

   always #5 clk = ~clk;

   // Destination master of an RID: 0, 1, or -1 for an orphan.
   function automatic int tgt(input logic [7:0] id);
      case (id[7:4])
         4'h1:    return 0;
         4'h2:    return 1;
         default: return -1;
      endcase
   endfunction

   task automatic idle;
      sid = '0; sdata = '0; sresp = '0; slast = '0; svalid = '0;
   endtask

   task automatic drive_s(input int s, input logic [7:0] id, input logic [31:0] d, input logic l);
      sid[s] = id; sdata[s] = d; sresp[s] = 2'(s); slast[s] = l; svalid[s] = 1'b1;
   endtask

   task automatic step_clk;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst = 1'b0; idle(); mrdy = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
   endtask

   task automatic test_reset;
      rst = 1'b0; idle(); mrdy = 2'b11;
      drive_s(1, 8'h15, 32'hDEAD, 1'b1);
      @(negedge clk);
      n_chk++;
      if (mvalid !== 2'b00 || srdy !== 3'b000 || mdata[0] !== 32'd0 || mid[0] !== 4'd0) begin
         n_err++;
         $display("FAIL reset_hold: mvalid=%b srdy=%b data_m0=%h id_m0=%h, want all zero", mvalid, srdy, mdata[0], mid[0]);
      end
      @(posedge clk);
      #1 rst = 1'b1; idle();
      @(negedge clk);
      n_chk++;
      if (mvalid !== 2'b00 || srdy !== 3'b000) begin
         n_err++;
         $display("FAIL reset_idle: mvalid=%b srdy=%b, want 00/000", mvalid, srdy);
      end
      step_clk();
   endtask

   task automatic test_single_burst;
      do_reset(); mrdy = 2'b11;
      for (int i = 0; i < 4; i++) begin
         drive_s(1, 8'h15, 32'(i + 1), i == 3);
         @(negedge clk);
         n_chk++;
         if (mvalid !== 2'b01 || mid[0] !== 4'h5 || mdata[0] !== 32'(i + 1) || mlast[0] !== (i == 3)
             || mresp[0] !== 2'd1 || srdy !== 3'b010) begin
            n_err++;
            $display("FAIL single_burst beat %0d: mvalid=%b id=%h data=%h last=%b resp=%0d srdy=%b, want 01/5/%0h/%0b/1/010",
                     i, mvalid, mid[0], mdata[0], mlast[0], mresp[0], srdy, i + 1, i == 3);
         end
         step_clk();
      end
      idle();
      drive_s(0, 8'h1A, 32'h55, 1'b1);
      @(negedge clk);
      n_chk++;
      if (mvalid !== 2'b01 || mid[0] !== 4'hA || mdata[0] !== 32'h55 || srdy !== 3'b001) begin
         n_err++;
         $display("FAIL single_burst_idle: mvalid=%b id=%h data=%h srdy=%b, want 01/a/55/001", mvalid, mid[0], mdata[0], srdy);
      end
      step_clk(); idle();
   endtask

   task automatic test_arbitration;
      int          v0 [6] = '{1, 1, 0, 0, 1, 1};
      logic [31:0] d0 [6] = '{32'hA0, 32'hA1, 32'h0, 32'h0, 32'hB0, 32'hB1};
      int          l0 [6] = '{0, 1, 0, 0, 1, 1};
      logic [31:0] d2 [6] = '{32'hC0, 32'hC0, 32'hC0, 32'hC1, 32'hD0, 32'hD0};
      int          l2 [6] = '{0, 0, 0, 1, 1, 1};
      logic [31:0] ed [6] = '{32'hA0, 32'hA1, 32'hC0, 32'hC1, 32'hB0, 32'hD0};
      int          el [6] = '{0, 1, 0, 1, 1, 1};
      logic [2:0]  er [6] = '{3'b001, 3'b001, 3'b100, 3'b100, 3'b001, 3'b100};
      do_reset(); mrdy = 2'b10;
      for (int c = 0; c < 6; c++) begin
         idle();
         if (v0[c] != 0) drive_s(0, 8'h23, d0[c], l0[c] != 0);
         drive_s(2, 8'h23, d2[c], l2[c] != 0);
         @(negedge clk);
         n_chk++;
         if (mvalid !== 2'b10 || mid[1] !== 4'h3 || mdata[1] !== ed[c] || mlast[1] !== (el[c] != 0) || srdy !== er[c]) begin
            n_err++;
            $display("FAIL arbitration step %0d: mvalid=%b id=%h data=%h last=%b srdy=%b, want 10/3/%h/%0d/%b",
                     c, mvalid, mid[1], mdata[1], mlast[1], srdy, ed[c], el[c], er[c]);
         end
         step_clk();
      end
      idle();
   endtask

   task automatic test_concurrent;
      do_reset(); mrdy = 2'b11;
      for (int i = 0; i < 2; i++) begin
         drive_s(0, 8'h11, 32'h100 + 32'(i), i == 1);
         drive_s(2, 8'h27, 32'h200 + 32'(i), i == 1);
         @(negedge clk);
         n_chk++;
         if (mvalid !== 2'b11 || mid[0] !== 4'h1 || mid[1] !== 4'h7 || mdata[0] !== 32'h100 + 32'(i)
             || mdata[1] !== 32'h200 + 32'(i) || mresp[0] !== 2'd0 || mresp[1] !== 2'd2
             || mlast !== {2{i == 1}} || srdy !== 3'b101) begin
            n_err++;
            $display("FAIL concurrent beat %0d: mvalid=%b id=%h/%h data=%h/%h resp=%0d/%0d last=%b srdy=%b",
                     i, mvalid, mid[0], mid[1], mdata[0], mdata[1], mresp[0], mresp[1], mlast, srdy);
         end
         step_clk();
      end
      idle();
   endtask

   task automatic test_backpressure;
      logic [3:0]  eid;
      logic [31:0] edat;
      logic        elast;
      logic [2:0]  erdy;
      do_reset();
      for (int c = 0; c < 6; c++) begin
         idle();
         mrdy = (c >= 3) ? 2'b01 : 2'b00;
         if (c <= 3) drive_s(1, 8'h12, 32'h111, 1'b0);
         else if (c == 4) drive_s(1, 8'h12, 32'h112, 1'b1);
         if (c >= 1) drive_s(0, 8'h13, 32'h333, 1'b1);
         eid   = (c == 5) ? 4'h3 : 4'h2;
         edat  = (c == 5) ? 32'h333 : (c == 4) ? 32'h112 : 32'h111;
         elast = (c >= 4);
         erdy  = (c == 5) ? 3'b001 : (c >= 3) ? 3'b010 : 3'b000;
         @(negedge clk);
         n_chk++;
         if (mvalid !== 2'b01 || mid[0] !== eid || mdata[0] !== edat || mlast[0] !== elast || srdy !== erdy) begin
            n_err++;
            $display("FAIL backpressure step %0d: mvalid=%b id=%h data=%h last=%b srdy=%b, want 01/%h/%h/%b/%b",
                     c, mvalid, mid[0], mdata[0], mlast[0], srdy, eid, edat, elast, erdy);
         end
         step_clk();
      end
      idle();
   endtask

   task automatic test_orphan;
      do_reset(); mrdy = 2'b11;
      for (int i = 0; i < 2; i++) begin
         drive_s(2, 8'h42, 32'hBAD0 + 32'(i), i == 1);
         @(negedge clk);
         n_chk++;
         if (srdy !== 3'b100 || mvalid !== 2'b00) begin
            n_err++;
            $display("FAIL orphan beat %0d: srdy=%b mvalid=%b, want 100/00", i, srdy, mvalid);
         end
         step_clk();
      end
      idle();
   endtask

   task automatic test_reset_mid_burst;
      do_reset(); mrdy = 2'b01;
      drive_s(1, 8'h1F, 32'h50, 1'b1);
      step_clk(); idle();
      drive_s(1, 8'h15, 32'h61, 1'b0);
      @(negedge clk);
      n_chk++;
      if (mvalid !== 2'b01 || mdata[0] !== 32'h61) begin
         n_err++;
         $display("FAIL rst_mid_beat1: mvalid=%b data=%h, want 01/61", mvalid, mdata[0]);
      end
      step_clk();
      drive_s(1, 8'h15, 32'h62, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      n_chk++;
      if (mvalid !== 2'b00 || srdy !== 3'b000 || mdata[0] !== 32'd0 || mid[0] !== 4'd0) begin
         n_err++;
         $display("FAIL rst_mid_async: mvalid=%b srdy=%b data=%h id=%h, want all zero", mvalid, srdy, mdata[0], mid[0]);
      end
      @(posedge clk);
      #1 rst = 1'b1; idle();
      drive_s(0, 8'h1C, 32'h70, 1'b1);
      drive_s(2, 8'h1D, 32'h80, 1'b1);
      @(negedge clk);
      n_chk++;
      if (mvalid !== 2'b01 || mid[0] !== 4'hC || mdata[0] !== 32'h70 || srdy !== 3'b001) begin
         n_err++;
         $display("FAIL rst_mid_rr0: mvalid=%b id=%h data=%h srdy=%b, want 01/c/70/001", mvalid, mid[0], mdata[0], srdy);
      end
      step_clk();
      svalid[0] = 1'b0;
      @(negedge clk);
      n_chk++;
      if (mvalid !== 2'b01 || mid[0] !== 4'hD || mdata[0] !== 32'h80 || srdy !== 3'b100) begin
         n_err++;
         $display("FAIL rst_mid_next: mvalid=%b id=%h data=%h srdy=%b, want 01/d/80/100", mvalid, mid[0], mdata[0], srdy);
      end
      step_clk(); idle();
      drive_s(1, 8'h16, 32'h90, 1'b1);
      @(negedge clk);
      n_chk++;
      if (mvalid !== 2'b01 || mid[0] !== 4'h6 || mdata[0] !== 32'h90 || srdy !== 3'b010) begin
         n_err++;
         $display("FAIL rst_mid_s1: mvalid=%b id=%h data=%h srdy=%b, want 01/6/90/010", mvalid, mid[0], mdata[0], srdy);
      end
      step_clk(); idle();
   endtask

   task automatic test_random;
      int         lock [2], src [2], rr [2], es [2], rem [3];
      bit         ev [2], er [3], hs [3];
      int         t, si;
      logic [3:0] tag;
      do_reset();
      for (int m = 0; m < 2; m++) begin lock[m] = 0; src[m] = 0; rr[m] = 0; end
      for (int s = 0; s < 3; s++) begin rem[s] = 0; hs[s] = 1'b0; end
      for (int cyc = 0; cyc < 600; cyc++) begin
         mrdy = 2'($urandom);
         for (int s = 0; s < 3; s++) begin
            if (!svalid[s] || hs[s]) begin
               if (hs[s]) rem[s]--;
               svalid[s] = 1'b0;
               if (rem[s] == 0 && $urandom_range(1) == 1) begin
                  t       = $urandom_range(4);
                  tag     = (t < 2) ? 4'h1 : (t < 4) ? 4'h2 : 4'h7;
                  sid[s]  = {tag, 4'($urandom)};
                  rem[s]  = $urandom_range(4, 1);
               end
               if (rem[s] > 0 && $urandom_range(3) != 0) begin
                  sdata[s] = $urandom; sresp[s] = 2'($urandom);
                  slast[s] = (rem[s] == 1); svalid[s] = 1'b1;
               end
            end
         end
         @(negedge clk);
         for (int m = 0; m < 2; m++) begin
            es[m] = lock[m] ? src[m] : -1;
            if (lock[m] == 0) begin
               for (int k = 0; k < 3; k++) begin
                  si = (rr[m] + k) % 3;
                  if (es[m] < 0 && svalid[si] && tgt(sid[si]) == m) es[m] = si;
               end
            end
            ev[m] = (es[m] >= 0) && svalid[es[m]];
            n_chk++;
            if (mvalid[m] !== ev[m]) begin
               n_err++;
               $display("FAIL random cyc %0d valid_m%0d: got %b want %b", cyc, m, mvalid[m], ev[m]);
            end else if (ev[m]) begin
               n_chk++;
               if ({mid[m], mdata[m], mresp[m], mlast[m]} !== {sid[es[m]][3:0], sdata[es[m]], sresp[es[m]], slast[es[m]]}) begin
                  n_err++;
                  $display("FAIL random cyc %0d beat_m%0d: got id=%h data=%h resp=%0d last=%b want slave %0d",
                           cyc, m, mid[m], mdata[m], mresp[m], mlast[m], es[m]);
               end
            end
         end
         for (int s = 0; s < 3; s++) begin
            er[s] = svalid[s] && tgt(sid[s]) < 0;
            for (int m = 0; m < 2; m++)
               if (ev[m] && es[m] == s && mrdy[m]) er[s] = 1'b1;
            if (svalid[s]) begin
               n_chk++;
               if (srdy[s] !== er[s]) begin
                  n_err++;
                  $display("FAIL random cyc %0d ready_s%0d: got %b want %b", cyc, s, srdy[s], er[s]);
               end
            end
            hs[s] = svalid[s] && er[s];
         end
         for (int m = 0; m < 2; m++) begin
            if (ev[m] && mrdy[m] && slast[es[m]]) begin
               lock[m] = 0;
               rr[m]   = (es[m] + 1) % 3;
            end else if (ev[m]) begin
               lock[m] = 1;
               src[m]  = es[m];
            end
         end
         step_clk();
      end
      idle(); mrdy = '0;
   endtask

   initial begin
      rst = 1'b0; idle(); mrdy = '0;
      step_clk();
      test_reset();
      test_single_burst();
      test_arbitration();
      test_concurrent();
      test_backpressure();
      test_orphan();
      test_reset_mid_burst();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/axi_r_ch.md
Name: axi_r_ch

Overview:
- Read-data (R) channel router of the 2-master / 3-slave AXI interconnect.
- Sits directly downstream of the read-address channel crossbar. That crossbar forwards AR with an extended ID whose upper nibble tags the issuing master.
- This block returns slave R beats to the tagging master, arbitrating among slaves per master and holding the path for a whole burst.
- Slaves S0..S2 are the sources; masters M0/M1 are the destinations.

Parameters:
- ID_BITS, 4, master-side ID width.
- IDS_BITS, 8, slave-side ID width; bits [IDS_BITS-1:ID_BITS] are the master tag.
- DATA_BITS, 32, RDATA width.
- RESP_BITS, 2, RRESP width.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous, active-low reset.
- id_s{0,1,2}_i  input  IDS_BITS  slave RID (tag + master ID).
- data_s{0,1,2}_i  input  DATA_BITS  slave RDATA.
- resp_s{0,1,2}_i  input  RESP_BITS  slave RRESP.
- last_s{0,1,2}_i  input  1  slave RLAST.
- valid_s{0,1,2}_i  input  1  slave RVALID.
- ready_s{0,1,2}_o  output  1  RREADY to slave.
- id_m{0,1}_o  output  ID_BITS  RID to master, equal to id_sX_i[ID_BITS-1:0].
- data_m{0,1}_o  output  DATA_BITS  RDATA to master.
- resp_m{0,1}_o  output  RESP_BITS  RRESP to master.
- last_m{0,1}_o  output  1  RLAST to master.
- valid_m{0,1}_o  output  1  RVALID to master.
- ready_m{0,1}_i  input  1  master RREADY.

Behaviour:
- Tag decode:
  - Tag 4'b0001 targets M0.
  - Tag 4'b0010 targets M1.
  - Any other tag is an orphan.
- Orphan beats are sunk: ready_sX_o=1 while valid_sX_i=1; the beat is discarded and appears on no master.
- Each master has an independent path FSM: states IDLE and LOCK, a 2-bit src register and a 2-bit round-robin pointer rr.
- Candidates for master m: slaves with valid_sX_i=1 and tag targeting m.
- IDLE:
  - Select the first candidate in order rr, rr+1, rr+2 (mod 3).
  - Drive its id/data/resp/last/valid to master m combinationally; zero-cycle latency.
  - valid & ~ready: go LOCK, src=selected. The selection stays frozen so the master never sees valid drop or the payload change.
  - Handshake with last=0: go LOCK, src=selected.
  - Handshake with last=1: stay IDLE, rr=selected+1 (mod 3).
  - No candidate: all master outputs 0.
- LOCK:
  - Outputs come only from src; other slaves targeting m are stalled (ready 0).
  - Handshake with last=1: go IDLE, rr=src+1 (mod 3).
  - valid_src dropping mid-burst: valid_m=0 and LOCK is held.
- Slave ready: ready_sX_o = (selected by M0 & ready_m0_i) | (selected by M1 & ready_m1_i) | orphan sink. Tag decode is one-hot, so a slave is never selected by both masters.
- Slaves targeting different masters proceed concurrently in the same cycle.
- ready_m is not gated by valid; a handshake is only counted when valid & ready.
- Reset (asynchronous, any time, including mid-burst):
  - FSMs to IDLE, src=0, rr=0.
  - All master outputs 0 and all ready_sX_o 0 while rst=0.
  - No partial-burst state survives reset.
- Burst length is not counted; RLAST alone ends a lock.

Optional Feature:
- Macro: AXI_R_CH_SKID_EN.
- Defined:
  - Each master output passes through a 2-entry skid buffer (main + skid register).
  - Adds exactly 1 cycle latency and keeps full throughput (1 beat/cycle with ready held high).
  - The buffer's ready (not ready_m directly) drives the internal handshake, so ready_sX_o no longer depends combinationally on ready_mX_i.
  - FSM transitions occur on the internal handshake.
  - Reset empties both entries.
- Not defined: the combinational path described above, zero latency.

Test Plan:
- S1 sends a 4-beat burst with id 8'h15, data 1..4, ready_m0=1 → M0 sees 4 consecutive beats, id 4'h5, last on beat 4; M1 valid stays 0; FSM back to IDLE.
- S0 and S2 both present id 8'h23 with 2-beat bursts in the same cycle, rr=0 → M1 receives both S0 beats, then both S2 beats; S2 ready=0 until S0's last handshakes; rr=1 afterwards.
- S0 sends to M0 (8'h11) while S2 sends to M1 (8'h27) concurrently, both readys 1 → both complete in the same cycles with no cross-talk.
- S1 valid, id 8'h12, ready_m0=0 for 3 cycles, then S0 asserts id 8'h13 → M0 payload stays S1's for all 3 cycles; S0 served only after S1's last.
- Orphan id 8'h42 on S2 for 2 beats → ready_s2=1 both cycles; valid_m0=valid_m1=0.
- rst asserted during beat 2 of 4 → all outputs 0 immediately; after release a new S1 burst to M0 is granted normally starting from rr=0.
